// File: rtl/bitonic_stream_loader.sv
// bitonic_stream_loader
// Deserialises a one-word-per-cycle valid/ready stream into DEPTH-wide
// frames for the downstream bitonic sorter. Each completed frame is
// presented for exactly one cycle on seq_out with valid_out high.
//
// A frame that ends early (in_last before DEPTH words) is completed with a
// sort-neutral pad word, so that the pads collect at the tail once the frame
// is sorted. pad_count tells the consumer how many tail slots to drop.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous reset, active low (0 = reset)
//   in_valid   input word valid
//   in_ready   loader can accept a word this cycle (low while padding)
//   in_data    input word, WIDTH bits, unsigned
//   in_last    accepted word is the final word of its frame
//   seq_out    emitted frame, index 0 = first word received
//   valid_out  one-cycle pulse marking a complete frame on seq_out
//   pad_count  number of padded tail slots in the emitted frame
//   frame_cnt  (BITONIC_LOADER_STATS_EN only) count of emitted frames
//   short_cnt  (BITONIC_LOADER_STATS_EN only) count of emitted padded frames
//
// Optional feature: define BITONIC_LOADER_STATS_EN to add the frame_cnt and
// short_cnt statistics outputs. Without it the module has no such ports.
module bitonic_stream_loader #(
  parameter int   DEPTH = 8,
  parameter int   WIDTH = 32,
  parameter logic DIR   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic [WIDTH-1:0]         seq_out [DEPTH-1:0],
  output logic                     valid_out,
  output logic [$clog2(DEPTH)-1:0] pad_count
`ifdef BITONIC_LOADER_STATS_EN
  ,
  output logic [31:0]              frame_cnt,
  output logic [31:0]              short_cnt
`endif
);

  localparam int               CW       = $clog2(DEPTH);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEPTH - 1);
  // Ascending sorters push all-ones to the tail, descending ones push zero.
  localparam logic [WIDTH-1:0] PAD_VAL  = DIR ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  typedef enum logic [0:0] {
    FILL = 1'b0,
    PAD  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    pad_r_q, pad_r_d;
  logic [WIDTH-1:0] frame_q [DEPTH-1:0];
  logic [WIDTH-1:0] frame_d [DEPTH-1:0];
  logic             emit_s;
  logic [CW-1:0]    emit_pad_s;
  logic             in_ready_s;

  logic             valid_q;
  logic [CW-1:0]    pad_count_q;
  logic [WIDTH-1:0] seq_q [DEPTH-1:0];

  // Next-state logic: slot writes, counter advance and frame completion.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pad_r_d    = pad_r_q;
    frame_d    = frame_q;
    emit_s     = 1'b0;
    emit_pad_s = CNT_ZERO;
    in_ready_s = 1'b0;
    case (state_q)
      FILL: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          frame_d[cnt_q] = in_data;
          if (cnt_q == CNT_LAST) begin
            // Full frame: in_last is irrelevant here, no pads.
            emit_s = 1'b1;
            cnt_d  = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (in_last) begin
              pad_r_d = CNT_LAST - cnt_q;
              state_d = PAD;
            end else begin
              state_d = FILL;
            end
          end
        end else begin
          state_d = FILL;
        end
      end
      PAD: begin
        frame_d[cnt_q] = PAD_VAL;
        if (cnt_q == CNT_LAST) begin
          emit_s     = 1'b1;
          emit_pad_s = pad_r_q;
          cnt_d      = CNT_ZERO;
          state_d    = FILL;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, buffer and registered output stage. The output copy takes the
  // next-state buffer so the word written on the completing edge is included.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FILL;
      cnt_q       <= CNT_ZERO;
      pad_r_q     <= CNT_ZERO;
      valid_q     <= 1'b0;
      pad_count_q <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        frame_q[i] <= {WIDTH{1'b0}};
        seq_q[i]   <= {WIDTH{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pad_r_q     <= pad_r_d;
      valid_q     <= emit_s;
      pad_count_q <= emit_s ? emit_pad_s : CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        frame_q[i] <= frame_d[i];
        seq_q[i]   <= emit_s ? frame_d[i] : {WIDTH{1'b0}};
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign valid_out = valid_q;
  assign pad_count = pad_count_q;
  assign seq_out   = seq_q;

`ifdef BITONIC_LOADER_STATS_EN
  logic [31:0] frame_cnt_q;
  logic [31:0] short_cnt_q;

  // Statistics counters, updated on the same edge that raises valid_out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_q <= 32'd0;
      short_cnt_q <= 32'd0;
    end else begin
      if (emit_s) begin
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end else begin
        frame_cnt_q <= frame_cnt_q;
      end
      if (emit_s && (emit_pad_s != CNT_ZERO)) begin
        short_cnt_q <= short_cnt_q + 32'd1;
      end else begin
        short_cnt_q <= short_cnt_q;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign short_cnt = short_cnt_q;
`endif

endmodule

// File: tb/tb_bitonic_stream_loader.sv
// tb_bitonic_stream_loader
// Drives word streams into two loaders (DIR=1 and DIR=0) sharing one input
// stream. Expected frames come from a list model: the words of a frame,
// followed by pad words up to DEPTH, emitted on the cycle after the last
// slot is filled.
module tb_bitonic_stream_loader;

  localparam int DEPTH = 8;
  localparam logic [31:0] PAD1 = 32'hFFFF_FFFF;

  typedef struct {
    logic [DEPTH-1:0][31:0] data;
    logic [2:0]             pad;
    int                     cyc;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready0;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] seq_out [DEPTH-1:0];
  logic [31:0] seq0    [DEPTH-1:0];
  logic        valid_out, valid0;
  logic [2:0]  pad_count, pad0;
`ifdef BITONIC_LOADER_STATS_EN
  logic [31:0] frame_cnt, short_cnt, frame_cnt0, short_cnt0;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int idle_bad = 0;
  frame_t exp_q[$], got_q[$], exp0_q[$], got0_q[$];
  logic [31:0] wbuf [DEPTH];

  bitonic_stream_loader #(.DEPTH(DEPTH), .WIDTH(32), .DIR(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .seq_out(seq_out),
    .valid_out(valid_out), .pad_count(pad_count)
`ifdef BITONIC_LOADER_STATS_EN
    , .frame_cnt(frame_cnt), .short_cnt(short_cnt)
`endif
  );

  bitonic_stream_loader #(.DEPTH(DEPTH), .WIDTH(32), .DIR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .seq_out(seq0),
    .valid_out(valid0), .pad_count(pad0)
`ifdef BITONIC_LOADER_STATS_EN
    , .frame_cnt(frame_cnt0), .short_cnt(short_cnt0)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture emitted frames; outside a pulse the outputs must be all zero.
  always @(negedge clk) begin
    frame_t f;
    if (valid_out === 1'b1) begin
      for (int i = 0; i < DEPTH; i++) f.data[i] = seq_out[i];
      f.pad = pad_count;
      f.cyc = cyc;
      got_q.push_back(f);
    end else begin
      for (int i = 0; i < DEPTH; i++) if (seq_out[i] !== 32'h0) idle_bad++;
      if (pad_count !== 3'd0) idle_bad++;
      if (valid_out !== 1'b0) idle_bad++;
    end
    if (valid0 === 1'b1) begin
      for (int i = 0; i < DEPTH; i++) f.data[i] = seq0[i];
      f.pad = pad0;
      f.cyc = cyc;
      got0_q.push_back(f);
    end
  end

  // Offer one word after gap idle cycles; returns the edge index it was accepted on.
  task automatic push(input logic [31:0] d, input logic l, input int gap, output int e);
    int w;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    w = 0;
    while (in_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) begin
      total++;
      bad++;
      $display("FAIL push_timeout in_ready=%b required=1", in_ready);
    end
    e = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Send wbuf[0..n-1] as one frame and queue the expected emitted frames.
  task automatic send_frame(input int n, input int max_gap);
    int e;
    logic l;
    frame_t f, f0;
    e = 0;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) l = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      else l = 1'b0;
      push(wbuf[i], l, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, e);
    end
    for (int i = 0; i < DEPTH; i++) begin
      f.data[i]  = (i < n) ? wbuf[i] : PAD1;
      f0.data[i] = (i < n) ? wbuf[i] : 32'h0;
    end
    f.pad  = 3'(DEPTH - n);
    f.cyc  = e + (DEPTH - n);
    f0.pad = f.pad;
    f0.cyc = f.cyc;
    exp_q.push_back(f);
    exp0_q.push_back(f0);
  endtask

  task automatic clear_queues();
    exp_q.delete(); got_q.delete(); exp0_q.delete(); got0_q.delete();
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (got_q.size() < exp_q.size() && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    logic nz;
    rst = 1'b0;
    in_valid = 1'b1;
    in_last = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_data = $urandom;
      @(negedge clk);
      nz = 1'b0;
      for (int i = 0; i < DEPTH; i++) if (seq_out[i] !== 32'h0) nz = 1'b1;
      total++;
      if (valid_out !== 1'b0 || nz !== 1'b0 || pad_count !== 3'd0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d valid=%b seq_nonzero=%b pad=%0d required 0/0/0", c, valid_out, nz, pad_count);
      end
    end
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || valid_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_release in_ready=%b valid=%b required 1/0", in_ready, valid_out);
    end
  endtask

  task automatic test_full_frame();
    logic [31:0] v [DEPTH] = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd5, 32'd2, 32'd8, 32'd4};
    clear_queues();
    for (int i = 0; i < DEPTH; i++) wbuf[i] = v[i];
    send_frame(DEPTH, 0);
    drain();
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL full_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].pad !== exp_q[i].pad || got_q[i].cyc != exp_q[i].cyc) begin
        bad++;
        $display("FAIL full_frame data=%h pad=%0d cyc=%0d required data=%h pad=%0d cyc=%0d",
                 got_q[i].data, got_q[i].pad, got_q[i].cyc, exp_q[i].data, exp_q[i].pad, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_queues();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
      send_frame(DEPTH, 0);
    end
    drain();
    total++;
    if (got_q.size() != 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d required=3", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].pad !== exp_q[i].pad || got_q[i].cyc != exp_q[i].cyc) begin
        bad++;
        $display("FAIL b2b_frame%0d data=%h pad=%0d cyc=%0d required data=%h pad=%0d cyc=%0d", i,
                 got_q[i].data, got_q[i].pad, got_q[i].cyc, exp_q[i].data, exp_q[i].pad, exp_q[i].cyc);
      end
      if (i > 0) begin
        total++;
        if (got_q[i].cyc - got_q[i-1].cyc != DEPTH) begin
          bad++;
          $display("FAIL b2b_spacing got=%0d required=%0d", got_q[i].cyc - got_q[i-1].cyc, DEPTH);
        end
      end
    end
  endtask

  task automatic test_short_frame();
    int lo;
    clear_queues();
    wbuf[0] = 32'd10; wbuf[1] = 32'd20; wbuf[2] = 32'd30;
    send_frame(3, 0);
    lo = 0;
    while (in_ready === 1'b0 && lo < 20) begin
      lo++;
      @(negedge clk);
    end
    total++;
    if (lo != 5) begin
      bad++;
      $display("FAIL short_ready_low got=%0d required=5", lo);
    end
    drain();
    total++;
    if (got_q.size() != 1 || got0_q.size() != 1) begin
      bad++;
      $display("FAIL short_count got=%0d/%0d required=1/1", got_q.size(), got0_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].pad !== exp_q[i].pad || got_q[i].cyc != exp_q[i].cyc) begin
        bad++;
        $display("FAIL short_frame data=%h pad=%0d cyc=%0d required data=%h pad=%0d cyc=%0d",
                 got_q[i].data, got_q[i].pad, got_q[i].cyc, exp_q[i].data, exp_q[i].pad, exp_q[i].cyc);
      end
    end
    for (int i = 0; i < exp0_q.size() && i < got0_q.size(); i++) begin
      total++;
      if (got0_q[i].data !== exp0_q[i].data || got0_q[i].pad !== exp0_q[i].pad || got0_q[i].cyc != exp0_q[i].cyc) begin
        bad++;
        $display("FAIL short_frame_dir0 data=%h pad=%0d cyc=%0d required data=%h pad=%0d cyc=%0d",
                 got0_q[i].data, got0_q[i].pad, got0_q[i].cyc, exp0_q[i].data, exp0_q[i].pad, exp0_q[i].cyc);
      end
    end
  endtask

  task automatic test_single_and_gaps();
    clear_queues();
    wbuf[0] = 32'd42;
    send_frame(1, 0);
    for (int f = 0; f < 6; f++) begin
      int n;
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
      send_frame(n, 3);
    end
    drain();
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL gaps_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].pad !== exp_q[i].pad || got_q[i].cyc != exp_q[i].cyc) begin
        bad++;
        $display("FAIL gaps_frame%0d data=%h pad=%0d cyc=%0d required data=%h pad=%0d cyc=%0d", i,
                 got_q[i].data, got_q[i].pad, got_q[i].cyc, exp_q[i].data, exp_q[i].pad, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int e;
    clear_queues();
    for (int i = 0; i < 4; i++) push($urandom, 1'b0, 0, e);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push($urandom, 1'b0, 0, e);
    push($urandom, 1'b1, 0, e);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midpad_reset_ready got=%b required=1", in_ready);
    end
    for (int i = 0; i < DEPTH - 1; i++) push($urandom, 1'b0, 0, e);
    in_valid = 1'b1;
    in_data  = $urandom;
    rst      = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
    send_frame(DEPTH, 0);
    drain();
    total++;
    if (got_q.size() != 1) begin
      bad++;
      $display("FAIL midreset_count got=%0d required=1", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].pad !== exp_q[i].pad || got_q[i].cyc != exp_q[i].cyc) begin
        bad++;
        $display("FAIL midreset_frame data=%h pad=%0d cyc=%0d required data=%h pad=%0d cyc=%0d",
                 got_q[i].data, got_q[i].pad, got_q[i].cyc, exp_q[i].data, exp_q[i].pad, exp_q[i].cyc);
      end
    end
  endtask

`ifdef BITONIC_LOADER_STATS_EN
  task automatic test_stats();
    clear_queues();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
      send_frame(DEPTH, 1);
    end
    for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
    send_frame(5, 1);
    drain();
    total++;
    if (frame_cnt !== 32'd3 || short_cnt !== 32'd1) begin
      bad++;
      $display("FAIL stats frame_cnt=%0d short_cnt=%0d required 3/1", frame_cnt, short_cnt);
    end
  endtask
`endif

  task automatic test_idle_zero();
    total++;
    if (idle_bad != 0) begin
      bad++;
      $display("FAIL idle_outputs nonzero_samples=%0d required=0", idle_bad);
    end
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h0;
    in_last  = 1'b0;
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_short_frame();
    test_single_and_gaps();
    test_reset_mid_frame();
`ifdef BITONIC_LOADER_STATS_EN
    test_stats();
`endif
    test_idle_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
